key_search_ctrl: RTL

Top-level sequencer for the RC4 key-search flow on the DE1-SoC. Repeats, for each candidate key, three phases: S-memory init, key scheduling, and PRGA decrypt into DM. Watches the decrypt writes to DM and accepts the key only when every plaintext byte is a lowercase letter or a space; otherwise it steps to the next key. Sits above the three phase units and beside the S-memory port mux, which it steers through its phase outputs.

---
 rtl/rc4_pkg.sv | 39 +++
 rtl/msg_char_check.sv | 69 ++++++
 rtl/key_search_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared constants, controller state encoding and the plaintext
// character rule for the RC4 key-search flow.
//   KEY_W        candidate key width
//   KEY_MAX      last legal key (top two bits zero)
//   MSG_LEN      number of DM bytes one decrypt writes
//   WDOG_CYCLES  per-phase timeout in cycles
//   is_plain_char(b) is 1 for lowercase ASCII letters and space

package rc4_pkg;

    localparam int unsigned KEY_W       = 24;
    localparam logic [23:0] KEY_MAX     = 24'h3FFFFF;
    localparam int unsigned MSG_LEN     = 32;
    localparam int unsigned WDOG_CYCLES = 4096;
    localparam int unsigned WDOG_W      = $clog2(WDOG_CYCLES) + 1;
    // Byte counter is wider than MSG_LEN needs and saturates, so an
    // over-long message can never wrap back onto MSG_LEN.
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_KSA   = 3'd2,
        ST_PRGA  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_FOUND = 3'd5,
        ST_FAIL  = 3'd6
    } ctrl_state_t;

    localparam logic [1:0] PSEL_NONE = 2'd0;
    localparam logic [1:0] PSEL_INIT = 2'd1;
    localparam logic [1:0] PSEL_KSA  = 2'd2;
    localparam logic [1:0] PSEL_PRGA = 2'd3;

    function automatic logic is_plain_char(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

endpackage

// File: rtl/msg_char_check.sv
// msg_char_check: watches DM writes during a decrypt, counts them and latches
// whether any written byte falls outside the plaintext alphabet.
//   clk, reset_n    clock, asynchronous active-low reset
//   clr             synchronous clear of count and bad latch (wins over en)
//   en              count/check writes only while high (PRGA phase)
//   dm_wren         snooped DM write enable
//   dm_wdata        snooped DM write data
//   bad             latched bad flag OR a bad byte being written this cycle,
//                   so the controller can reject in the same cycle
//   byte_cnt        number of writes seen since the last clear (saturating)

module msg_char_check
    import rc4_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             dm_wren,
    input  logic [7:0]       dm_wdata,
    output logic             bad,
    output logic [CNT_W-1:0] byte_cnt
);

    logic             bad_q;
    logic             bad_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wr_s;
    logic             hit_s;

    // Next-state for the write counter and the bad latch.
    always_comb begin
        wr_s  = en & dm_wren;
        hit_s = wr_s & ~is_plain_char(dm_wdata);
        cnt_d = cnt_q;
        bad_d = bad_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
            bad_d = 1'b0;
        end else begin
            if (wr_s && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
            if (hit_s) begin
                bad_d = 1'b1;
            end else begin
                bad_d = bad_q;
            end
        end
    end

    // Counter and bad latch registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
            bad_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bad_q <= bad_d;
        end
    end

    assign bad      = bad_q | hit_s;
    assign byte_cnt = cnt_q;

endmodule

// File: rtl/key_search_ctrl.sv
// key_search_ctrl: sequences S-init, KSA and PRGA for one candidate key at a
// time, rejects keys whose plaintext is not lowercase/space, and steps the
// key by a stride until a key is accepted or the key space is used up.
//   clk, reset_n                  clock, asynchronous active-low reset
//   go, stop                      start pulse (IDLE/FOUND/FAIL), cancel level
//   key_start, key_stride         first key and increment, sampled on go
//   init/ksa/prga_start           one-cycle start pulses to the phase units
//   init/ksa/prga_done            one-cycle done pulses from the phase units
//   phase_abort                   one-cycle pulse returning phase units to idle
//   phase_sel                     S-port owner: 0 none, 1 init, 2 ksa, 3 prga
//   dm_wren, dm_wdata             snooped DM writes
//   key                           current candidate key
//   busy, found, exhausted, timeout  status flags
// All outputs are registered.

module key_search_ctrl
    import rc4_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic             stop,
    input  logic [KEY_W-1:0] key_start,
    input  logic [KEY_W-1:0] key_stride,
    output logic             init_start,
    output logic             ksa_start,
    output logic             prga_start,
    input  logic             init_done,
    input  logic             ksa_done,
    input  logic             prga_done,
    output logic             phase_abort,
    output logic [1:0]       phase_sel,
    input  logic             dm_wren,
    input  logic [7:0]       dm_wdata,
    output logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic             timeout
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MSG_CNT   = CNT_W'(MSG_LEN);

    ctrl_state_t      state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] stride_q, stride_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic             init_start_q, init_start_d;
    logic             ksa_start_q, ksa_start_d;
    logic             prga_start_q, prga_start_d;
    logic             abort_q, abort_d;
    logic [1:0]       phase_sel_q, phase_sel_d;
    logic             busy_q, busy_d;
    logic             found_q, found_d;
    logic             exhausted_q, exhausted_d;
    logic             timeout_q, timeout_d;

    logic [KEY_W:0]   sum_s;
    logic             wdog_hit_s;
    logic             clr_s;
    logic             en_s;
    logic             bad_s;
    logic [CNT_W-1:0] byte_cnt_s;

    assign en_s = (state_q == ST_PRGA);

    msg_char_check u_msg_char_check (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr_s),
        .en       (en_s),
        .dm_wren  (dm_wren),
        .dm_wdata (dm_wdata),
        .bad      (bad_s),
        .byte_cnt (byte_cnt_s)
    );

    // Next-state, key/stride update, watchdog and registered-output values.
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        stride_d     = stride_q;
        wdog_d       = {WDOG_W{1'b0}};
        init_start_d = 1'b0;
        ksa_start_d  = 1'b0;
        prga_start_d = 1'b0;
        abort_d      = 1'b0;
        found_d      = found_q;
        exhausted_d  = exhausted_q;
        timeout_d    = timeout_q;
        clr_s        = 1'b0;
        // One extra bit so a stride past the top of the key space is visible.
        sum_s        = {1'b0, key_q} + {1'b0, stride_q};
        wdog_hit_s   = (wdog_q == WDOG_LAST);

        if (stop && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            abort_d     = 1'b1;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            timeout_d   = 1'b0;
            clr_s       = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_FOUND, ST_FAIL: begin
                    if (go) begin
                        state_d      = ST_INIT;
                        key_d        = key_start;
                        stride_d     = key_stride;
                        found_d      = 1'b0;
                        exhausted_d  = 1'b0;
                        timeout_d    = 1'b0;
                        clr_s        = 1'b1;
                        init_start_d = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_INIT: begin
                    if (init_done) begin
                        state_d     = ST_KSA;
                        ksa_start_d = 1'b1;
                    end else if (wdog_hit_s) begin
                        state_d   = ST_FAIL;
                        abort_d   = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + WDOG_W'(1);
                    end
                end
                ST_KSA: begin
                    if (ksa_done) begin
                        state_d      = ST_PRGA;
                        prga_start_d = 1'b1;
                    end else if (wdog_hit_s) begin
                        state_d   = ST_FAIL;
                        abort_d   = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + WDOG_W'(1);
                    end
                end
                ST_PRGA: begin
                    if (bad_s) begin
                        // A unit that has just signalled done is already idle.
                        state_d = ST_NEXT;
                        abort_d = ~prga_done;
                    end else if (prga_done) begin
                        state_d = ST_NEXT;
                    end else if (wdog_hit_s) begin
                        state_d   = ST_FAIL;
                        abort_d   = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + WDOG_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (!bad_s && (byte_cnt_s == MSG_CNT)) begin
                        state_d = ST_FOUND;
                        found_d = 1'b1;
                    end else if (sum_s > {1'b0, KEY_MAX}) begin
                        state_d     = ST_FAIL;
                        exhausted_d = 1'b1;
                    end else begin
                        state_d      = ST_INIT;
                        key_d        = sum_s[KEY_W-1:0];
                        clr_s        = 1'b1;
                        init_start_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_INIT) || (state_d == ST_KSA) ||
                 (state_d == ST_PRGA) || (state_d == ST_NEXT);

        case (state_d)
            ST_INIT: phase_sel_d = PSEL_INIT;
            ST_KSA:  phase_sel_d = PSEL_KSA;
            ST_PRGA: phase_sel_d = PSEL_PRGA;
            default: phase_sel_d = PSEL_NONE;
        endcase
    end

    // State, key, watchdog and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            key_q        <= {KEY_W{1'b0}};
            stride_q     <= {KEY_W{1'b0}};
            wdog_q       <= {WDOG_W{1'b0}};
            init_start_q <= 1'b0;
            ksa_start_q  <= 1'b0;
            prga_start_q <= 1'b0;
            abort_q      <= 1'b0;
            phase_sel_q  <= PSEL_NONE;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            stride_q     <= stride_d;
            wdog_q       <= wdog_d;
            init_start_q <= init_start_d;
            ksa_start_q  <= ksa_start_d;
            prga_start_q <= prga_start_d;
            abort_q      <= abort_d;
            phase_sel_q  <= phase_sel_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            timeout_q    <= timeout_d;
        end
    end

    assign init_start  = init_start_q;
    assign ksa_start   = ksa_start_q;
    assign prga_start  = prga_start_q;
    assign phase_abort = abort_q;
    assign phase_sel   = phase_sel_q;
    assign key         = key_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign timeout     = timeout_q;

endmodule
